// File: rtl/alu_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_pkg
// Brief    : Opcodes, flag bit positions and FSM state type for alu_mc.
// Revision : 1.0 - initial release
// ============================================================================
package alu_mc_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_ADC  = 5'd2;
    localparam logic [4:0] OP_SBC  = 5'd3;
    localparam logic [4:0] OP_INC  = 5'd4;
    localparam logic [4:0] OP_DEC  = 5'd5;
    localparam logic [4:0] OP_NAND = 5'd6;
    localparam logic [4:0] OP_NOT  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd16;
    localparam logic [4:0] OP_SHR  = 5'd17;
    localparam logic [4:0] OP_SAR  = 5'd18;
    localparam logic [4:0] OP_ROL  = 5'd19;
    localparam logic [4:0] OP_MULL = 5'd20;
    localparam logic [4:0] OP_MULH = 5'd21;
    localparam logic [4:0] OP_CMP  = 5'd22;

    localparam int F_Z = 0;
    localparam int F_P = 1;
    localparam int F_C = 2;
    localparam int F_S = 3;
    localparam int F_V = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_if
// Brief    : Request handshake and result bus between decode and alu_mc.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       sel;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] opi;
    logic             out_valid;
    logic [WIDTH-1:0] res;
    logic [4:0]       flag;

    modport master (
        output in_valid, sel, op1, op2, opi,
        input  in_ready, out_valid, res, flag
    );

    modport slave (
        input  in_valid, sel, op1, op2, opi,
        output in_ready, out_valid, res, flag
    );
endinterface
`default_nettype wire

// File: rtl/alu_mc_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Brief    : WIDTH-step shift-add unsigned multiplier; done marks the edge
//            on which prod (the final step, combinational) is valid.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic [WIDTH-1:0]   a,
    input  wire logic [WIDTH-1:0]   b,
    output logic                    done,
    output logic [2*WIDTH-1:0]      prod
);
    localparam int c_CW = $clog2(WIDTH + 1);

    logic [c_CW-1:0]    r_count;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     w_upper;
    logic [2*WIDTH-1:0] w_step;

    // Multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        w_upper = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
        w_step  = {w_upper, r_acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_a     <= '0;
            r_acc   <= '0;
        end else if (start) begin
            r_count <= c_CW'(WIDTH);
            r_a     <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
        end else if (r_count != '0) begin
            r_count <= r_count - c_CW'(1);
            r_acc   <= w_step;
        end
    end

    assign done = (r_count == c_CW'(1));
    assign prod = w_step;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Brief    : Multi-cycle ALU with valid/ready input, single-cycle datapath
//            and a sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_mc_if.slave   bus
);
    localparam int c_MSB = WIDTH - 1;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_res, w_res_nxt;
    logic [4:0]         r_flag, w_flag_nxt;
    logic               r_out_valid, w_ov_nxt;
    logic               r_mul_hi;

    logic [WIDTH-1:0]   w_b, w_u, w_x, w_y;
    logic               w_ci, w_sub, w_ovf;
    logic [WIDTH:0]     w_sum;
    logic [SHW-1:0]     w_amt;
    logic [WIDTH:0]     w_shl, w_shr;
    logic signed [WIDTH:0] w_sar;
    logic [WIDTH-1:0]   w_rol;
    logic [WIDTH-1:0]   w_sh_res;
    logic               w_sh_c;
    logic [WIDTH-1:0]   w_alu_res;
    logic [4:0]         w_alu_flag;
    logic               w_zps;

    logic               w_mul_start, w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mul_res;
    logic               w_mul_hi_nz;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (w_mul_start),
        .a     (bus.op1),
        .b     (bus.op2),
        .done  (w_mul_done),
        .prod  (w_prod)
    );

    always_comb begin : p_alu
        w_b   = (!bus.sel[4] && bus.sel[3]) ? bus.opi : bus.op2;
        w_u   = bus.sel[3] ? w_b : bus.op1;
        w_amt = w_b[SHW-1:0];

        w_x   = bus.op1;
        w_y   = w_b;
        w_ci  = 1'b0;
        w_sub = 1'b0;
        if (bus.sel == OP_CMP) begin
            w_sub = 1'b1;
        end else if (!bus.sel[4]) begin
            case (bus.sel[2:0])
                3'd1: w_sub = 1'b1;
                3'd2: w_ci  = r_flag[F_C];
                3'd3: begin w_ci = r_flag[F_C]; w_sub = 1'b1; end
                3'd4: begin w_x = w_u; w_y = WIDTH'(1); end
                3'd5: begin w_x = w_u; w_y = WIDTH'(1); w_sub = 1'b1; end
                default: ;
            endcase
        end
        w_sum = w_sub ? ({1'b0, w_x} - {1'b0, w_y} - {{WIDTH{1'b0}}, w_ci})
                      : ({1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_ci});
        w_ovf = (w_sub ? (w_x[c_MSB] != w_y[c_MSB]) : (w_x[c_MSB] == w_y[c_MSB]))
                && (w_sum[c_MSB] != w_x[c_MSB]);

        // Guard bit on the exit side of each shifter holds the last bit out.
        w_shl = {1'b0, bus.op1} << w_amt;
        w_shr = {bus.op1, 1'b0} >> w_amt;
        w_sar = $signed({bus.op1, 1'b0}) >>> w_amt;
        w_rol = (bus.op1 << w_amt) | (bus.op1 >> (WIDTH - int'(w_amt)));
        case (bus.sel[1:0])
            2'd0:    begin w_sh_res = w_shl[WIDTH-1:0]; w_sh_c = w_shl[WIDTH]; end
            2'd1:    begin w_sh_res = w_shr[WIDTH:1];   w_sh_c = w_shr[0];     end
            2'd2:    begin w_sh_res = w_sar[WIDTH:1];   w_sh_c = w_sar[0];     end
            default: begin w_sh_res = w_rol;            w_sh_c = w_rol[0];     end
        endcase

        w_alu_res  = r_res;
        w_alu_flag = r_flag;
        w_zps      = 1'b0;
        if (!bus.sel[4]) begin
            w_zps = 1'b1;
            case (bus.sel[2:0])
                3'd6:    w_alu_res = ~(bus.op1 & w_b);
                3'd7:    w_alu_res = ~w_u;
                default: begin
                    w_alu_res       = w_sum[WIDTH-1:0];
                    w_alu_flag[F_C] = w_sum[WIDTH];
                    w_alu_flag[F_V] = w_ovf;
                end
            endcase
        end else begin
            case (bus.sel)
                OP_SHL, OP_SHR, OP_SAR, OP_ROL: begin
                    w_zps     = 1'b1;
                    w_alu_res = w_sh_res;
                    if (w_amt != '0) w_alu_flag[F_C] = w_sh_c;
                    w_alu_flag[F_V] = 1'b0;
                end
                OP_CMP: begin
                    w_alu_flag[F_Z] = (w_sum[WIDTH-1:0] == '0);
                    w_alu_flag[F_P] = ^w_sum[WIDTH-1:0];
                    w_alu_flag[F_S] = w_sum[c_MSB];
                    w_alu_flag[F_C] = w_sum[WIDTH];
                    w_alu_flag[F_V] = w_ovf;
                end
                default: ;
            endcase
        end
        if (w_zps) begin
            w_alu_flag[F_Z] = (w_alu_res == '0);
            w_alu_flag[F_P] = ^w_alu_res;
            w_alu_flag[F_S] = w_alu_res[c_MSB];
        end
    end

    always_comb begin : p_fsm
        w_state_nxt  = r_state;
        w_res_nxt    = r_res;
        w_flag_nxt   = r_flag;
        w_ov_nxt     = 1'b0;
        w_mul_start  = 1'b0;
        bus.in_ready = 1'b0;
        w_mul_res    = r_mul_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
        w_mul_hi_nz  = (w_prod[2*WIDTH-1:WIDTH] != '0);
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.sel == OP_MULL || bus.sel == OP_MULH) begin
                        w_mul_start = 1'b1;
                        w_state_nxt = ST_MUL;
                    end else begin
                        w_res_nxt  = w_alu_res;
                        w_flag_nxt = w_alu_flag;
                        w_ov_nxt   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_res_nxt        = w_mul_res;
                    w_flag_nxt[F_Z]  = (w_mul_res == '0);
                    w_flag_nxt[F_P]  = ^w_mul_res;
                    w_flag_nxt[F_S]  = w_mul_res[c_MSB];
                    w_flag_nxt[F_C]  = w_mul_hi_nz;
                    w_flag_nxt[F_V]  = w_mul_hi_nz;
                    w_ov_nxt         = 1'b1;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_res       <= '0;
            r_flag      <= '0;
            r_out_valid <= 1'b0;
            r_mul_hi    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_res       <= w_res_nxt;
            r_flag      <= w_flag_nxt;
            r_out_valid <= w_ov_nxt;
            if (w_mul_start) r_mul_hi <= bus.sel[0];
        end
    end

    assign bus.res       = r_res;
    assign bus.flag      = r_flag;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire
